// File: rtl/soc_event_token_bridge.sv
// +--------------------------------------------------------------------------+
// | soc_event_token_bridge: arbitrates NB_SRC valid/ack event sources into   |
// | a circular slot buffer exposed through a write-token / read-pointer pair.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module soc_event_token_bridge #(
   parameter int NB_SRC       = 4,
   parameter int EVNT_WIDTH   = 8,
   parameter int BUFFER_WIDTH = 8,
   parameter int PRIO_MODE    = 0,
   parameter int DROP_ON_FULL = 0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [NB_SRC-1:0]                  src_valid_i,
   input  logic [NB_SRC*EVNT_WIDTH-1:0]       src_data_i,
   output logic [NB_SRC-1:0]                  src_ack_o,
   output logic [BUFFER_WIDTH-1:0]            events_wt_o,
   input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
   output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
   output logic [$clog2(BUFFER_WIDTH)-1:0]    fill_o,
   output logic [15:0]                        drop_cnt_o,
   output logic                               rp_err_o
);

   localparam int IW  = $clog2(BUFFER_WIDTH);
   localparam int IW1 = IW + 1;
   localparam int PW  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;

   logic [EVNT_WIDTH-1:0]   slots [BUFFER_WIDTH];
   logic [PW-1:0]           ptr;
   logic [PW-1:0]           gnt_idx;
   logic                    gnt_any;
   logic                    grant;
   logic                    full;
   logic                    rp_onehot;
   logic [NB_SRC-1:0]       eligible;
   logic [BUFFER_WIDTH-1:0] wt_rotl;
   logic [IW-1:0]           wt_idx;
   logic [IW-1:0]           rp_idx;
   logic [IW1-1:0]          fill_diff;
   logic [EVNT_WIDTH-1:0]   gnt_data;

   assign rp_onehot = $onehot(events_rp_i);
   assign wt_rotl   = {events_wt_o[BUFFER_WIDTH-2:0], events_wt_o[BUFFER_WIDTH-1]};
   // An illegal read pointer blocks writes exactly like a full buffer.
   assign full      = (wt_rotl == events_rp_i) || !rp_onehot;
   // The ack cycle masks a source so a held event is never captured twice.
   assign eligible  = src_valid_i & ~src_ack_o;
   assign grant     = gnt_any && (!full || (DROP_ON_FULL != 0));

   always_comb begin
      wt_idx = '0;
      rp_idx = '0;
      for (int k = 0; k < BUFFER_WIDTH; k++) begin
         if (events_wt_o[k]) wt_idx = wt_idx | IW'(k);
         if (events_rp_i[k]) rp_idx = rp_idx | IW'(k);
      end
   end

   always_comb begin
      fill_diff = {1'b0, wt_idx} - {1'b0, rp_idx};
      if (wt_idx < rp_idx) fill_diff = fill_diff + IW1'(BUFFER_WIDTH);
      fill_o = fill_diff[IW-1:0];
   end

   always_comb begin
      int c;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NB_SRC; k++) begin
         c = (PRIO_MODE != 0) ? k : ((int'(ptr) + k) % NB_SRC);
         if (!gnt_any && eligible[c]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(c);
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < NB_SRC; k++) begin
         if (gnt_idx == PW'(k)) gnt_data = src_data_i[k*EVNT_WIDTH +: EVNT_WIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         events_wt_o <= BUFFER_WIDTH'(1);
         src_ack_o   <= '0;
         drop_cnt_o  <= '0;
         rp_err_o    <= 1'b0;
         ptr         <= '0;
         for (int k = 0; k < BUFFER_WIDTH; k++) slots[k] <= '0;
      end else begin
         src_ack_o <= '0;
         if (!rp_onehot) rp_err_o <= 1'b1;
         if (grant) begin
            src_ack_o[gnt_idx] <= 1'b1;
            ptr <= (gnt_idx == PW'(NB_SRC - 1)) ? '0 : gnt_idx + PW'(1);
            if (!full) begin
               slots[wt_idx] <= gnt_data;
               events_wt_o   <= wt_rotl;
            end else if (drop_cnt_o != 16'hFFFF) begin
               drop_cnt_o <= drop_cnt_o + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < BUFFER_WIDTH; g++) begin : g_slot_out
      assign events_da_o[g*EVNT_WIDTH +: EVNT_WIDTH] = slots[g];
   end

endmodule

`default_nettype wire

// File: tb/tb_soc_event_token_bridge.sv
// +--------------------------------------------------------------------------+
// | tb_soc_event_token_bridge: directed bench for soc_event_token_bridge,    |
// | round-robin/stall instance (a) and fixed-priority/drop instance (b).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_soc_event_token_bridge;

   logic        clk;
   logic        rst;
   logic [3:0]  valid;
   logic [31:0] data;
   logic [7:0]  rp;

   logic [3:0]  a_ack,  b_ack;
   logic [7:0]  a_wt,   b_wt;
   logic [63:0] a_da,   b_da;
   logic [2:0]  a_fill, b_fill;
   logic [15:0] a_drop, b_drop;
   logic        a_err,  b_err;

   int checks   = 0;
   int failures = 0;
   int a_acks;
   int b_acks;

   soc_event_token_bridge #(.NB_SRC(4), .EVNT_WIDTH(8), .BUFFER_WIDTH(8),
                            .PRIO_MODE(0), .DROP_ON_FULL(0)) dut_a (
      .clk_i(clk), .rst_i(rst), .src_valid_i(valid), .src_data_i(data),
      .src_ack_o(a_ack), .events_wt_o(a_wt), .events_rp_i(rp), .events_da_o(a_da),
      .fill_o(a_fill), .drop_cnt_o(a_drop), .rp_err_o(a_err));

   soc_event_token_bridge #(.NB_SRC(4), .EVNT_WIDTH(8), .BUFFER_WIDTH(8),
                            .PRIO_MODE(1), .DROP_ON_FULL(1)) dut_b (
      .clk_i(clk), .rst_i(rst), .src_valid_i(valid), .src_data_i(data),
      .src_ack_o(b_ack), .events_wt_o(b_wt), .events_rp_i(rp), .events_da_o(b_da),
      .fill_o(b_fill), .drop_cnt_o(b_drop), .rp_err_o(b_err));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; valid = '0; data = '0; rp = 8'h01;
      step(); step();
      rst = 1'b0;
      chk("reset_wt",   a_wt,   8'h01);
      chk("reset_ack",  a_ack,  4'b0000);
      chk("reset_fill", a_fill, 3'd0);
      chk("reset_drop", a_drop, 16'd0);
      chk("reset_err",  a_err,  1'b0);
      chk("reset_da",   a_da,   64'd0);

      // single event from source 2
      valid = 4'b0100; data = 32'h00A5_0000;
      step();
      valid = '0;
      chk("single_ack",  a_ack,      4'b0100);
      chk("single_slot", a_da[7:0],  8'hA5);
      chk("single_wt",   a_wt,       8'h02);
      chk("single_fill", a_fill,     3'd1);
      chk("single_ackb", b_ack,      4'b0100);
      step();
      chk("single_ack_drop", a_ack,  4'b0000);

      rst = 1'b1; step(); rst = 1'b0;

      // all sources continuously valid
      valid = 4'b1111; data = 32'h1312_1110;
      step(); chk("rr0", a_ack, 4'b0001); chk("fp0", b_ack, 4'b0001);
      step(); chk("rr1", a_ack, 4'b0010); chk("fp1", b_ack, 4'b0010);
      step(); chk("rr2", a_ack, 4'b0100); chk("fp2", b_ack, 4'b0001);
      step(); chk("rr3", a_ack, 4'b1000); chk("fp3", b_ack, 4'b0010);
      step(); chk("rr4", a_ack, 4'b0001); chk("fp4", b_ack, 4'b0001);
      valid = '0;
      chk("rr_fill",  a_fill,       3'd5);
      chk("rr_slot1", a_da[15:8],   8'h11);
      chk("rr_slot4", a_da[39:32],  8'h10);
      chk("fp_slot2", b_da[23:16],  8'h10);

      rst = 1'b1; step(); rst = 1'b0;

      // ten single-cycle offers from source 0 against a frozen consumer
      a_acks = 0; b_acks = 0;
      for (int e = 0; e < 10; e++) begin
         valid = 4'b0001; data = 32'hC0 + e;
         step();
         if (a_ack[0]) a_acks++;
         if (b_ack[0]) b_acks++;
         valid = '0;
         step();
      end
      chk("stall_acks", a_acks, 7);
      chk("stall_wt",   a_wt,   8'h80);
      chk("stall_fill", a_fill, 3'd7);
      chk("stall_drop", a_drop, 16'd0);
      chk("drop_acks",  b_acks, 10);
      chk("drop_cnt",   b_drop, 16'd3);
      chk("drop_wt",    b_wt,   8'h80);
      chk("drop_slots", b_da[55:0], 56'hC6C5C4C3C2C1C0);

      valid = 4'b0001; data = 32'hCA;
      step(); chk("stall_hold0", a_ack, 4'b0000); chk("drop_hold0", b_ack, 4'b0001);
      step(); chk("stall_hold1", a_ack, 4'b0000);
      chk("drop_cnt4", b_drop, 16'd4);
      rp = 8'h02;
      step();
      valid = '0;
      chk("free_ack",   a_ack,        4'b0001);
      chk("free_wt",    a_wt,         8'h01);
      chk("free_fill",  a_fill,       3'd7);
      chk("free_slot7", a_da[63:56],  8'hCA);
      chk("free_wtb",   b_wt,         8'h01);
      chk("free_dropb", b_drop,       16'd4);

      // illegal read pointer
      rp = 8'h03; valid = 4'b0010; data = 32'h0000_EE00;
      step();
      valid = '0;
      chk("err_set",    a_err,  1'b1);
      chk("err_noack",  a_ack,  4'b0000);
      chk("err_nowt",   a_wt,   8'h01);
      chk("err_ackb",   b_ack,  4'b0010);
      chk("err_dropb",  b_drop, 16'd5);
      chk("err_nowtb",  b_wt,   8'h01);
      rp = 8'h01;
      step();
      chk("err_sticky",  a_err,      1'b1);
      chk("err_stickyb", b_err,      1'b1);
      chk("err_slot0",   a_da[7:0],  8'hC0);
      chk("err_slot0b",  b_da[7:0],  8'hC0);

      // reset in the cycle a valid arrives
      rst = 1'b1; valid = 4'b0001; data = 32'h77;
      step();
      rst = 1'b0; valid = '0;
      chk("rstv_ack",  a_ack,  4'b0000);
      chk("rstv_wt",   a_wt,   8'h01);
      chk("rstv_fill", a_fill, 3'd0);
      chk("rstv_err",  a_err,  1'b0);
      chk("rstv_da",   a_da,   64'd0);
      chk("rstv_drop", b_drop, 16'd0);
      chk("rstv_ackb", b_ack,  4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
